ahbs_fifo_port: RTL and testbench

Fabric-side AHB slave that terminates the core's AHB slave port (the ahbs_* fabric interface). It gives the MIPS a word-wide, memory-mapped TX FIFO, which the fabric logic drains through a valid/ready stream. It also gives a word-wide RX FIFO, which the fabric logic fills through a valid/ready stream. The block inserts AHB wait states for TX-full and RX-empty conditions, and returns an ERROR response on timeout or for an unsupported access size.

---
 rtl/ahbs_fifo_port.sv | 251 +++++++++++++++++++++++++
 tb/tb_ahbs_fifo_port.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbs_fifo_port.sv
// AHB slave port exposing a word-wide TX FIFO and RX FIFO to the core.
// Wait states on TX-full / RX-empty, ERROR on timeout or bad size.
module ahbs_fifo_port #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL_CNT = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_FULL_CNT = RX_DEPTH[RAW:0];
  localparam logic [7:0] WAIT_LIM = MAX_WAIT[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state;

  logic [1:0] a_addr;
  logic       a_write;
  logic       a_legal;
  logic [7:0] wcnt;

  logic [31:0]    tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp;
  logic [TAW-1:0] tx_rp;
  logic [TAW:0]   tx_cnt;

  logic [31:0]    rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp;
  logic [RAW-1:0] rx_rp;
  logic [RAW:0]   rx_cnt;

  logic rx_irq_en;

  logic tx_full;
  logic tx_empty;
  logic rx_full;
  logic rx_empty;
  logic addr_ok;
  logic busy;
  logic is_tx_wr;
  logic is_rx_rd;
  logic is_ctrl_wr;
  logic stall;
  logic complete;
  logic capture;
  logic tx_flush;
  logic rx_flush;
  logic tx_push;
  logic tx_pop;
  logic rx_push;
  logic rx_pop;
  logic [4:0]  tx_cnt5;
  logic [4:0]  rx_cnt5;
  logic [31:0] status;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{haddr[31:4], haddr[1:0], htrans[0]};

  assign tx_full  = tx_cnt == TX_FULL_CNT;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == RX_FULL_CNT;
  assign rx_empty = rx_cnt == '0;

  assign addr_ok    = hsel & htrans[1] & hready;
  assign busy       = (state == S_DATA) | (state == S_WAIT);
  assign is_tx_wr   = a_write & (a_addr == 2'd0);
  assign is_rx_rd   = ~a_write & (a_addr == 2'd1);
  assign is_ctrl_wr = a_write & (a_addr == 2'd3);

  // A transfer stalls on a TX push into a full FIFO or an RX pop from empty
  assign stall    = (is_tx_wr & tx_full) | (is_rx_rd & rx_empty);
  assign complete = busy & a_legal & ~stall;
  assign capture  = addr_ok &
                    (complete | (state == S_IDLE) | (state == S_ERR2));

  assign tx_flush = complete & is_ctrl_wr & hwdata[0];
  assign rx_flush = complete & is_ctrl_wr & hwdata[1];
  assign tx_push  = complete & is_tx_wr;
  assign tx_pop   = ~tx_empty & tx_ready;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = complete & is_rx_rd;

  assign tx_cnt5 = 5'(tx_cnt);
  assign rx_cnt5 = 5'(rx_cnt);

  assign status = {11'b0, rx_irq_en,
                   rx_empty, rx_full, tx_empty, tx_full,
                   3'b0, rx_cnt5, 3'b0, tx_cnt5};

  // Read-data source selected by the registered address
  always_comb begin
    rd_data = '0;
    unique case (a_addr)
      2'd1:    rd_data = rx_mem[rx_rp];
      2'd2:    rd_data = status;
      2'd3:    rd_data = {29'b0, rx_irq_en, 2'b0};
      default: rd_data = '0;
    endcase
  end

  assign hrdata     = (complete & ~a_write) ? rd_data : '0;
  assign hready_out = complete | (state == S_IDLE) | (state == S_ERR2);
  assign hresp      = ((state == S_ERR1) | (state == S_ERR2)) ?
                      2'b01 : 2'b00;

  assign tx_data  = tx_mem[tx_rp];
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  // Bus FSM: address capture, wait-state counting and error sequencing
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_legal <= 1'b0;
      wcnt    <= '0;
    end else begin
      if (capture) begin
        a_addr  <= haddr[3:2];
        a_write <= hwrite;
        a_legal <= hsize == 3'b010;
      end
      unique case (state)
        S_IDLE: begin
          if (capture) state <= S_DATA;
        end
        S_DATA: begin
          if (!a_legal) begin
            state <= S_ERR1;
          end else if (stall) begin
            state <= S_WAIT;
            wcnt  <= '0;
          end else begin
            state <= capture ? S_DATA : S_IDLE;
          end
        end
        S_WAIT: begin
          if (!stall) begin
            state <= capture ? S_DATA : S_IDLE;
          end else if (wcnt + 8'd1 == WAIT_LIM) begin
            state <= S_ERR1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_ERR1: begin
          state <= S_ERR2;
        end
        S_ERR2: begin
          state <= capture ? S_DATA : S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // TX pointers and occupancy; flush overrides any same-cycle push/pop
  always_ff @(posedge hclk) begin
    if (hreset | tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TAW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TAW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX storage
  always_ff @(posedge hclk) begin
    if (tx_push & ~hreset) tx_mem[tx_wp] <= hwdata;
  end

  // RX pointers and occupancy; flush overrides any same-cycle push/pop
  always_ff @(posedge hclk) begin
    if (hreset | rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RAW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RAW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // RX storage
  always_ff @(posedge hclk) begin
    if (rx_push & ~hreset & ~rx_flush) rx_mem[rx_wp] <= rx_data;
  end

  // Sticky interrupt enable from CTRL bit2
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rx_irq_en <= 1'b0;
    end else if (complete & is_ctrl_wr) begin
      rx_irq_en <= hwdata[2];
    end
  end

  // Registered data-available interrupt
  always_ff @(posedge hclk) begin
    if (hreset) begin
      irq <= 1'b0;
    end else begin
      irq <= rx_irq_en & ~rx_empty;
    end
  end

endmodule

// File: tb/tb_ahbs_fifo_port.sv
// Directed bench for ahbs_fifo_port.
// Bus HREADY loops back from hready_out (single slave).
module tb_ahbs_fifo_port;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  assign hready = hready_out;

  always #5 hclk = ~hclk;

  ahbs_fifo_port dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hready_out(hready_out),
    .hresp(hresp), .hrdata(hrdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  task automatic do_reset();
    hreset = 1'b1;
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  // Address phase, then move into the first data-phase cycle
  task automatic start(input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rsp,
                      output int waits);
    start(w, a, sz, wd);
    waits = 0;
    while (hready_out !== 1'b1 && waits < 64) begin
      waits++;
      @(negedge hclk);
    end
    rd = hrdata;
    rsp = hresp;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0;
    hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(negedge hclk);
    @(negedge hclk);
    n_chk++; if (hready_out !== 1'b1) begin n_fail++;
      $display("FAIL rst_hready got %b exp 1", hready_out); end
    n_chk++; if (hresp !== 2'b00) begin n_fail++;
      $display("FAIL rst_hresp got %b exp 00", hresp); end
    n_chk++; if (hrdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_hrdata got %h exp 0", hrdata); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_rx_ready got %b exp 1", rx_ready); end
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL rst_irq got %b exp 0", irq); end
    hreset = 1'b0;
  endtask

  task automatic test_tx_write();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h0, 3'b010, 32'hA5A5_0001, rd, rsp, w);
    n_chk++; if (w !== 0) begin n_fail++;
      $display("FAIL t1_waits got %0d exp 0", w); end
    n_chk++; if (rsp !== 2'b00) begin n_fail++;
      $display("FAIL t1_resp got %b exp 00", rsp); end
    @(negedge hclk);
    n_chk++; if (tx_valid !== 1'b1) begin n_fail++;
      $display("FAIL t1_tx_valid got %b exp 1", tx_valid); end
    n_chk++; if (tx_data !== 32'hA5A5_0001) begin n_fail++;
      $display("FAIL t1_tx_data got %h exp a5a50001", tx_data); end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h0008_0001) begin n_fail++;
      $display("FAIL t1_status got %h exp 00080001", rd); end
    xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h0) begin n_fail++;
      $display("FAIL t1_txdata_rd got %h exp 0", rd); end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd; logic [1:0] rsp; int w; int lows;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 32'h0, 3'b010, 32'h100 + i, rd, rsp, w);
      n_chk++; if (w !== 0) begin n_fail++;
        $display("FAIL t2_fill_waits[%0d] got %0d exp 0", i, w); end
    end
    start(1'b1, 32'h0, 3'b010, 32'h108);
    lows = 0;
    while (hready_out !== 1'b1 && lows < 64) begin
      lows++;
      tx_ready = (lows == 4);
      @(negedge hclk);
    end
    tx_ready = 1'b0;
    n_chk++; if (lows !== 4) begin n_fail++;
      $display("FAIL t2_full_waits got %0d exp 4", lows); end
    n_chk++; if (hresp !== 2'b00) begin n_fail++;
      $display("FAIL t2_full_resp got %b exp 00", hresp); end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h0009_0008) begin n_fail++;
      $display("FAIL t2_status got %h exp 00090008", rd); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h101 + i) begin
        n_fail++;
        $display("FAIL t2_order[%0d] got %b/%h exp 1/%h",
                 i, tx_valid, tx_data, 32'h101 + i);
      end
      tx_ready = 1'b1;
      @(negedge hclk);
    end
    tx_ready = 1'b0;
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL t2_drained got %b exp 0", tx_valid); end
  endtask

  task automatic test_rx_timeout();
    logic [31:0] rd; logic [1:0] rsp; int w; int lows; int errs;
    do_reset();
    start(1'b0, 32'h4, 3'b010, 32'h0);
    lows = 0; errs = 0;
    while (hready_out !== 1'b1 && lows < 64) begin
      if (hresp == 2'b01) errs++;
      lows++;
      @(negedge hclk);
    end
    if (hresp == 2'b01) errs++;
    n_chk++; if (lows !== 17) begin n_fail++;
      $display("FAIL t3_low_cycles got %0d exp 17", lows); end
    n_chk++; if (errs !== 2) begin n_fail++;
      $display("FAIL t3_err_cycles got %0d exp 2", errs); end
    n_chk++; if (hrdata !== 32'h0) begin n_fail++;
      $display("FAIL t3_hrdata got %h exp 0", hrdata); end
    @(negedge hclk);
    n_chk++; if (hresp !== 2'b00 || hready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_idle got %b/%b exp 00/1", hresp, hready_out);
    end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h000A_0000) begin n_fail++;
      $display("FAIL t3_status got %h exp 000a0000", rd); end
  endtask

  task automatic test_rx_wait_data();
    logic [31:0] rd; logic [1:0] rsp; int w; int lows;
    do_reset();
    start(1'b0, 32'h4, 3'b010, 32'h0);
    lows = 0;
    while (hready_out !== 1'b1 && lows < 64) begin
      lows++;
      rx_valid = (lows == 5);
      rx_data = 32'h1234_5678;
      @(negedge hclk);
    end
    rx_valid = 1'b0;
    n_chk++; if (lows !== 5) begin n_fail++;
      $display("FAIL t4_waits got %0d exp 5", lows); end
    n_chk++; if (hrdata !== 32'h1234_5678) begin n_fail++;
      $display("FAIL t4_hrdata got %h exp 12345678", hrdata); end
    n_chk++; if (hresp !== 2'b00) begin n_fail++;
      $display("FAIL t4_resp got %b exp 00", hresp); end
    @(negedge hclk);
    n_chk++; if (hrdata !== 32'h0) begin n_fail++;
      $display("FAIL t4_idle_hrdata got %h exp 0", hrdata); end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h000A_0000) begin n_fail++;
      $display("FAIL t4_status got %h exp 000a0000", rd); end
  endtask

  task automatic test_flush_irq();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 32'h0, 3'b010, 32'h200 + i, rd, rsp, w);
    end
    @(negedge hclk);
    rx_valid = 1'b1; rx_data = 32'h11;
    @(negedge hclk);
    rx_data = 32'h22;
    @(negedge hclk);
    rx_valid = 1'b0;
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h0000_0203) begin n_fail++;
      $display("FAIL t5_pre_status got %h exp 00000203", rd); end
    start(1'b1, 32'hC, 3'b010, 32'h7);
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 32'h33;
    n_chk++; if (hready_out !== 1'b1) begin n_fail++;
      $display("FAIL t5_ctrl_ready got %b exp 1", hready_out); end
    @(negedge hclk);
    tx_ready = 1'b0; rx_valid = 1'b0;
    n_chk++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_flushed got %b/%b exp 0/1", tx_valid, rx_ready);
    end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h001A_0000) begin n_fail++;
      $display("FAIL t5_status got %h exp 001a0000", rd); end
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL t5_irq_idle got %b exp 0", irq); end
    @(negedge hclk);
    rx_valid = 1'b1; rx_data = 32'hBEEF;
    @(negedge hclk);
    rx_valid = 1'b0;
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL t5_irq_early got %b exp 0", irq); end
    @(negedge hclk);
    n_chk++; if (irq !== 1'b1) begin n_fail++;
      $display("FAIL t5_irq_set got %b exp 1", irq); end
    xfer(1'b0, 32'h4, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'hBEEF || w !== 0) begin n_fail++;
      $display("FAIL t5_rx_rd got %h/%0d exp 0000beef/0", rd, w); end
  endtask

  task automatic test_bad_size();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h0, 3'b010, 32'h55, rd, rsp, w);
    xfer(1'b1, 32'h0, 3'b001, 32'h66, rd, rsp, w);
    n_chk++; if (w !== 2) begin n_fail++;
      $display("FAIL t6_err_waits got %0d exp 2", w); end
    n_chk++; if (rsp !== 2'b01) begin n_fail++;
      $display("FAIL t6_err_resp got %b exp 01", rsp); end
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h0008_0001) begin n_fail++;
      $display("FAIL t6_status got %h exp 00080001", rd); end
    n_chk++; if (tx_data !== 32'h55) begin n_fail++;
      $display("FAIL t6_tx_head got %h exp 55", tx_data); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic [1:0] rsp; int w;
    do_reset();
    xfer(1'b1, 32'h0, 3'b010, 32'h77, rd, rsp, w);
    xfer(1'b1, 32'h0, 3'b010, 32'h78, rd, rsp, w);
    start(1'b0, 32'h4, 3'b010, 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    n_chk++; if (hready_out !== 1'b0) begin n_fail++;
      $display("FAIL t7_in_wait got %b exp 0", hready_out); end
    hreset = 1'b1;
    @(negedge hclk);
    n_chk++; if (hready_out !== 1'b1 || hresp !== 2'b00) begin
      n_fail++;
      $display("FAIL t7_rst_bus got %b/%b exp 1/00", hready_out, hresp);
    end
    n_chk++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t7_rst_fifo got %b/%b exp 0/1", tx_valid, rx_ready);
    end
    hreset = 1'b0;
    xfer(1'b0, 32'h8, 3'b010, 32'h0, rd, rsp, w);
    n_chk++; if (rd !== 32'h000A_0000) begin n_fail++;
      $display("FAIL t7_status got %h exp 000a0000", rd); end
  endtask

  initial begin
    test_reset();
    test_tx_write();
    test_tx_full();
    test_rx_timeout();
    test_rx_wait_data();
    test_flush_irq();
    test_bad_size();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
